// File: rtl/rx_fis_ctrl.sv
// rx_fis_ctrl: walks inbound FIS frames from the FIFO, forwards Data-FIS payload to DMA,
// and reports the type, dword length and error status of each completed frame.
module rx_fis_ctrl #(
    parameter int C_MAX_DW = 7,
    parameter int C_LEN_W  = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               port2rxctl_en,
    input  logic               ififo2port_empty,
    input  logic [35:0]        ififo2rxdma_ndr_rd_do,
    output logic               rxdma2ififo_ndr_rd_en,
    output logic [31:0]        rxctl2dma_data,
    output logic               rxctl2dma_valid,
    output logic               rxctl2dma_last,
    input  logic               dma2rxctl_ready,
    output logic               rxctl2port_fis_done,
    output logic [7:0]         rxctl2port_fis_type,
    output logic [C_LEN_W-1:0] rxctl2port_fis_len,
    output logic               rxctl2port_fis_err,
    output logic               rxctl_busy
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, CTRL, DROP, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] typ, typ_nxt;
    logic [C_LEN_W-1:0] len, len_nxt, len_inc;
    logic err, err_nxt, pop, sof, eof, werr, at_max, unused_bit;
    assign sof = ififo2rxdma_ndr_rd_do[35];
    assign eof = ififo2rxdma_ndr_rd_do[34];
    assign werr = ififo2rxdma_ndr_rd_do[33];
    assign unused_bit = ififo2rxdma_ndr_rd_do[32];
    assign len_inc = (len == '1) ? len : len + 1'b1;
    assign at_max = len == C_LEN_W'(C_MAX_DW);
    always_comb begin
        state_nxt = state;
        typ_nxt = typ;
        len_nxt = len;
        err_nxt = err;
        pop = 1'b0;
        case (state)
            IDLE: state_nxt = (port2rxctl_en && !ififo2port_empty) ? HDR : IDLE;
            HDR: begin
                pop = sof;
                err_nxt = err | !sof;
                typ_nxt = sof ? ififo2rxdma_ndr_rd_do[7:0] : typ;
                len_nxt = sof ? C_LEN_W'(1) : len;
                state_nxt = !sof ? DROP : eof ? DONE : (ififo2rxdma_ndr_rd_do[7:0] == 8'h46) ? DATA : CTRL;
            end
            DATA: begin
                pop = dma2rxctl_ready;
                state_nxt = (dma2rxctl_ready && eof) ? DONE : DATA;
            end
            CTRL: begin
                pop = 1'b1;
                err_nxt = err | at_max;
                state_nxt = eof ? DONE : at_max ? DROP : CTRL;
            end
            DROP: begin
                pop = 1'b1;
                state_nxt = eof ? DONE : DROP;
            end
            DONE: begin
                len_nxt = '0;
                err_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // header pop loads len=1 above; every later pop counts one dword
        if (pop && state != HDR) len_nxt = len_inc;
        if (pop && werr) err_nxt = 1'b1;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            typ <= '0;
            len <= '0;
            err <= 1'b0;
            rxctl2port_fis_type <= '0;
            rxctl2port_fis_len <= '0;
            rxctl2port_fis_err <= 1'b0;
        end else begin
            state <= state_nxt;
            typ <= typ_nxt;
            len <= len_nxt;
            err <= err_nxt;
            if (state_nxt == DONE) begin
                rxctl2port_fis_type <= typ_nxt;
                rxctl2port_fis_len <= len_nxt;
                rxctl2port_fis_err <= err_nxt;
            end
        end
    end
    assign rxdma2ififo_ndr_rd_en = pop;
    assign rxctl2dma_valid = state == DATA;
    assign rxctl2dma_data = ififo2rxdma_ndr_rd_do[31:0];
    assign rxctl2dma_last = rxctl2dma_valid & eof;
    assign rxctl2port_fis_done = state == DONE;
    assign rxctl_busy = state != IDLE;
endmodule

// File: tb/tb_rx_fis_ctrl.sv
// tb_rx_fis_ctrl: directed and randomized frames through a queue-based FIFO model,
// with expected frame results derived from the frame contents alone.
module tb_rx_fis_ctrl;
    localparam int MAX_DW = 7;
    logic sys_clk = 1'b0, sys_rst = 1'b1, en = 1'b1, empty, ready = 1'b0;
    logic rd_en, valid, last, done, busy, ferr;
    logic [35:0] head;
    logic [31:0] data;
    logic [7:0] ftype, d_type;
    logic [11:0] flen, d_len;
    logic d_err;
    logic [35:0] fifo[$], frm[$];
    logic [32:0] got[$];
    int pops = 0, vcyc = 0, done_cnt = 0, passed = 0, total = 0, pi = 0;
    bit use_pat = 1'b0;
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 sys_clk = ~sys_clk;

    rx_fis_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .port2rxctl_en(en), .ififo2port_empty(empty),
        .ififo2rxdma_ndr_rd_do(head), .rxdma2ififo_ndr_rd_en(rd_en), .rxctl2dma_data(data),
        .rxctl2dma_valid(valid), .rxctl2dma_last(last), .dma2rxctl_ready(ready),
        .rxctl2port_fis_done(done), .rxctl2port_fis_type(ftype), .rxctl2port_fis_len(flen),
        .rxctl2port_fis_err(ferr), .rxctl_busy(busy));

    // FIFO model and monitor; head/empty update with NBAs so the DUT sees a clean edge
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fifo.delete();
            head <= '0;
            empty <= 1'b1;
        end else begin
            if (rd_en) begin
                pops++;
                if (fifo.size() > 0) void'(fifo.pop_front());
            end
            if (valid && ready) got.push_back({last, data});
            if (valid) vcyc++;
            if (done) begin
                done_cnt++;
                d_type = ftype;
                d_len = flen;
                d_err = ferr;
            end
            head <= (fifo.size() > 0) ? fifo[0] : 36'h0;
            empty <= fifo.size() == 0;
        end
    end

    always @(negedge sys_clk) begin
        ready = use_pat ? pat[pi % 5] : 1'($urandom_range(0, 1));
        if (use_pat && valid) pi++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [35:0] mk(input bit s, input bit e, input bit r, input logic [31:0] d);
        return {s, e, r, 1'b0, d};
    endfunction

    task automatic build(input int n, input bit s, input logic [7:0] t, input int err_at);
        logic [31:0] w;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (i == 0) w[7:0] = t;
            frm.push_back(mk(i == 0 && s, i == n - 1, i == err_at, w));
        end
    endtask

    task automatic run_frame(input string tag, input bit push_it);
        int n = frm.size(), base = done_cnt, beats;
        bit s = frm[0][35], e, isdata;
        logic [7:0] t = frm[0][7:0];
        isdata = s && t == 8'h46;
        e = !s || (s && !isdata && n > MAX_DW);
        foreach (frm[i]) if (frm[i][33]) e = 1'b1;
        got.delete();
        pops = 0;
        vcyc = 0;
        if (push_it) foreach (frm[i]) fifo.push_back(frm[i]);
        for (int k = 0; k < 6000 && done_cnt == base; k++) @(posedge sys_clk);
        @(negedge sys_clk);
        chk({tag, ":done"}, done_cnt - base, 1);
        if (s) chk({tag, ":type"}, d_type, t);
        chk({tag, ":len"}, d_len, (n > 4095) ? 4095 : n);
        chk({tag, ":err"}, d_err, e);
        chk({tag, ":pops"}, pops, n);
        if (isdata) begin
            beats = got.size();
            chk({tag, ":beats"}, beats, n - 1);
            for (int i = 0; i < beats && i < n - 1; i++)
                chk({tag, ":beat"}, got[i], {i == n - 2, frm[i + 1][31:0]});
        end else chk({tag, ":novalid"}, vcyc, 0);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst:rd_en", rd_en, 0);
        chk("rst:valid", valid, 0);
        chk("rst:last", last, 0);
        chk("rst:done", done, 0);
        chk("rst:busy", busy, 0);
        chk("rst:len", flen, 0);
        chk("rst:type", ftype, 0);
        chk("rst:err", ferr, 0);
        @(negedge sys_clk) sys_rst = 1'b0;

        build(5, 1, 8'h34, -1);
        run_frame("reg34", 1);

        use_pat = 1'b1;
        pi = 0;
        build(4, 1, 8'h46, -1);
        run_frame("data46", 1);
        use_pat = 1'b0;

        build(3, 0, 8'h34, -1);
        run_frame("nosof", 1);

        build(9, 1, 8'h27, -1);
        run_frame("long9", 1);
        build(3, 1, 8'h27, -1);
        run_frame("after9", 1);

        build(7, 1, 8'h27, -1);
        run_frame("max7", 1);
        build(8, 1, 8'h27, -1);
        run_frame("over8", 1);
        build(4, 1, 8'h34, 2);
        run_frame("werr", 1);

        en = 1'b0;
        build(4, 1, 8'h46, -1);
        foreach (frm[i]) fifo.push_back(frm[i]);
        pops = 0;
        repeat (20) @(posedge sys_clk);
        #1;
        chk("en0:pops", pops, 0);
        chk("en0:busy", busy, 0);
        en = 1'b1;
        run_frame("en1", 0);

        for (int r = 0; r < 30; r++) begin
            int sel = $urandom_range(0, 2);
            build($urandom_range(1, 10), ($urandom % 8) != 0,
                  sel == 0 ? 8'h46 : sel == 1 ? 8'h34 : 8'($urandom),
                  ($urandom % 4) == 0 ? $urandom_range(0, 9) : -1);
            run_frame("rand", 1);
        end

        build(4100, 0, 8'h00, -1);
        run_frame("sat", 1);

        build(9, 1, 8'h46, -1);
        foreach (frm[i]) fifo.push_back(frm[i]);
        for (int k = 0; k < 50 && !valid; k++) @(negedge sys_clk);
        chk("midrst:valid_seen", valid, 1);
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        base = done_cnt;
        #1;
        chk("midrst:valid", valid, 0);
        chk("midrst:rd_en", rd_en, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:done", done, 0);
        @(negedge sys_clk) sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("midrst:nodone", done_cnt - base, 0);
        build(5, 1, 8'h34, -1);
        run_frame("recover", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rx_fis_ctrl.md
RX_FIS_CTRL -- requirements
Module: rx_fis_ctrl

Interface
REQ-001 SHALL have parameter C_MAX_DW, default 7, giving the maximum dword length (header included) of a non-Data FIS.
REQ-002 SHALL have parameter C_LEN_W, default 12, giving the width of the FIS dword-length counter.
REQ-003 sys_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 port2rxctl_en  in  1  high permits starting a new frame.
REQ-006 ififo2port_empty  in  1  high means no complete frame is buffered in the inbound FIFO.
REQ-007 ififo2rxdma_ndr_rd_do  in  36  first-word-fall-through FIFO head word: [31:0] data, [35] SOF, [34] EOF, [33] error, [32] ignored.
REQ-008 rxdma2ififo_ndr_rd_en  out  1  FIFO pop strobe.
REQ-009 rxctl2dma_data  out  32  Data-FIS payload word.
REQ-010 rxctl2dma_valid  out  1  payload word valid.
REQ-011 rxctl2dma_last  out  1  payload word is the frame's last word.
REQ-012 dma2rxctl_ready  in  1  DMA accepts the payload word.
REQ-013 rxctl2port_fis_done  out  1  one-cycle frame-complete pulse.
REQ-014 rxctl2port_fis_type  out  8  FIS type of the completed frame.
REQ-015 rxctl2port_fis_len  out  C_LEN_W  dwords popped for the frame, header included.
REQ-016 rxctl2port_fis_err  out  1  frame error flag, qualified by fis_done.
REQ-017 rxctl_busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, HDR, DATA, CTRL, DROP and DONE.
REQ-019 IDLE: when port2rxctl_en=1 and ififo2port_empty=0, go to HDR; SHALL not pop in IDLE.
REQ-020 HDR, head[35]=0: go to DROP and set err; SHALL not pop in the HDR cycle.
REQ-021 HDR, head[35]=1: latch type=head[7:0], pop the header and set len=1.
REQ-022 After the header pop: if head[34]=1 go to DONE; else if type=0x46 go to DATA; else go to CTRL.
REQ-023 DATA: valid=1; data=head[31:0]; last=head[34]; rd_en=valid&ready, combinational, with no added latency.
REQ-024 DATA: each pop increments len; popping a word with [34]=1 goes to DONE.
REQ-025 CTRL: rd_en=1 every cycle; len increments per pop.
REQ-026 CTRL: a pop with len already equal to C_MAX_DW sets err and goes to DROP; popping EOF goes to DONE.
REQ-027 DROP: rd_en=1 every cycle; len increments; popping EOF goes to DONE.
REQ-028 Any popped word with [33]=1 sets err.
REQ-029 rxctl2dma_valid SHALL be 0 outside DATA; CTRL and DROP words are never forwarded.
REQ-030 DONE: fis_done=1 for exactly one cycle; type, len and err are stable and registered; then go to IDLE and clear err and len.
REQ-031 type, len and err SHALL hold their values until the next DONE.
REQ-032 len SHALL saturate at 2^C_LEN_W-1 and SHALL not wrap.
REQ-033 port2rxctl_en is sampled only in IDLE; deasserting it mid-frame SHALL not stop the current frame.
REQ-034 The DONE cycle guarantees that IDLE sees the updated ififo2port_empty; back-to-back frames start no sooner than IDLE→HDR after DONE.
REQ-035 rd_en SHALL only assert in HDR(SOF), DATA, CTRL and DROP, and never in IDLE or DONE.

Reset
REQ-036 sys_rst=1 SHALL immediately force IDLE, set len=0, type=0, err=0, and set rd_en, valid, last, fis_done and busy to 0, regardless of the clock.
REQ-037 Reset mid-frame SHALL abandon the frame; the FIFO is reset by the same sys_rst, and the block SHALL not emit fis_done for that frame.

Verification
REQ-038 Register FIS type 0x34, 5 words (SOF on w0, EOF on w4), en=1 → 5 consecutive pops, valid never high, fis_done with type=0x34, len=5, err=0.
REQ-039 Data FIS 0x46 plus 3 payload words, ready pattern 1,0,1,0,1 → 3 valid&ready beats in order, last only on the 3rd, fis_done with len=4, err=0.
REQ-040 Head word without SOF, EOF 2 words later → pops until EOF, no valid, fis_done with err=1, len=3.
REQ-041 Non-data FIS of 9 words with C_MAX_DW=7 → all 9 popped, fis_done with err=1, len=9; the next frame processes cleanly with err=0.
REQ-042 en=0 with a frame buffered → no pops for 20 cycles; raising en → frame processed normally.
REQ-043 sys_rst asserted mid-DATA between clock edges → valid and rd_en drop at once, state is IDLE, no fis_done pulse.
